// File: rtl/miriscv_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_dmem_pkg
// Description : Shared constants, response type and store-legality helper
//               for the miriscv data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package miriscv_dmem_pkg;

    localparam int                   DMEM_XLEN        = 32;
    localparam logic [DMEM_XLEN-1:0] DMEM_ERR_DATA    = 32'hDEAD_BEEF;
    localparam int                   DMEM_MAX_LATENCY = 4;

    typedef struct packed {
        logic                 valid;
        logic [DMEM_XLEN-1:0] rdata;
    } dmem_resp_t;

    // Byte stores may use any lane; halfword and word stores must sit on
    // the lane their byte address points at.
    function automatic logic dmem_store_legal(input logic [3:0] be,
                                              input logic [1:0] offset);
        logic w_legal;
        w_legal = 1'b0;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_legal = 1'b1;
            4'b0011:                            w_legal = (offset == 2'b00);
            4'b1100:                            w_legal = (offset == 2'b10);
            4'b1111:                            w_legal = (offset == 2'b00);
            default:                            w_legal = 1'b0;
        endcase
        return w_legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_dmem_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_dmem_delay_line
// Description : LATENCY-deep shift register of load responses with
//               asynchronous active-high clear; data is held between pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_dmem_delay_line
    import miriscv_dmem_pkg::*;
#(
    parameter int LATENCY = 1
)(
    input  logic       clk,
    input  logic       rst,
    input  dmem_resp_t i_resp,
    output dmem_resp_t o_resp
);

    dmem_resp_t r_stage [LATENCY];

    // Data of a stage only moves with a valid token, so the last stage keeps
    // the most recent response data while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0].valid <= i_resp.valid;
            if (i_resp.valid) begin
                r_stage[0].rdata <= i_resp.rdata;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i].valid <= r_stage[i-1].valid;
                if (r_stage[i-1].valid) begin
                    r_stage[i].rdata <= r_stage[i-1].rdata;
                end
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/miriscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_dmem_responder
// Description : Data-memory slave for the miriscv core: byte-masked RAM,
//               fixed-latency in-order load responses, sticky error capture.
//               Optional store byte-enable checking: MIRISCV_DMEM_BE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_dmem_responder
    import miriscv_dmem_pkg::*;
#(
    parameter int              XLEN      = DMEM_XLEN,
    parameter int              DEPTH     = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 1,
    parameter string           INIT_FILE = ""
)(
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              err_o,
    output logic [XLEN-1:0]   err_addr_o
);

    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > DMEM_MAX_LATENCY) begin : g_bad_latency
        $error("miriscv_dmem_responder: LATENCY must be in 1..%0d", DMEM_MAX_LATENCY);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("miriscv_dmem_responder: DEPTH must be a power of two >= 2");
    end
    if (XLEN != DMEM_XLEN) begin : g_bad_xlen
        $error("miriscv_dmem_responder: XLEN must be %0d", DMEM_XLEN);
    end
    if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
        $error("miriscv_dmem_responder: BASE_ADDR must be DEPTH*4 aligned");
    end

    logic [XLEN-1:0] r_mem [DEPTH];

    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_be_ok;
    logic          w_store;
    logic          w_load;
    logic          w_err;

    // BASE_ADDR is aligned to the RAM size, so the range test reduces to the
    // upper address bits and the word index is taken straight from addr.
    assign w_in_range = (data_addr_i[XLEN-1:AW+2] == BASE_ADDR[XLEN-1:AW+2]);
    assign w_idx      = data_addr_i[AW+1:2];

`ifdef MIRISCV_DMEM_BE_CHECK_EN
    assign w_be_ok = dmem_store_legal(data_be_i, data_addr_i[1:0]);
`else
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^data_addr_i[1:0];
    assign w_be_ok           = 1'b1;
`endif

    assign w_store = data_req_i & data_we_i & w_in_range & w_be_ok & ~arst_i;
    assign w_load  = data_req_i & ~data_we_i;
    assign w_err   = data_req_i & (~w_in_range | (data_we_i & ~w_be_ok));

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (data_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    dmem_resp_t w_resp_in;
    dmem_resp_t w_resp_out;

    // The first delay stage captures the RAM word at the request edge.
    assign w_resp_in.valid = w_load;
    assign w_resp_in.rdata = w_in_range ? r_mem[w_idx] : DMEM_ERR_DATA;

    miriscv_dmem_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk    (clk_i),
        .rst    (arst_i),
        .i_resp (w_resp_in),
        .o_resp (w_resp_out)
    );

    assign data_rvalid_o = w_resp_out.valid;
    assign data_rdata_o  = w_resp_out.rdata;

    logic            r_err;
    logic [XLEN-1:0] r_err_addr;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= data_addr_i;
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_dmem_responder.sv
`default_nettype none
// Randomised scoreboard bench: two responder instances (LATENCY 1 and 3,
// different DEPTH/BASE_ADDR) share one stimulus stream and a reference model.
module tb_miriscv_dmem_responder;
    import miriscv_dmem_pkg::*;

    localparam int          LAT_A   = 1;
    localparam int          DEPTH_A = 64;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam int          LAT_B   = 3;
    localparam int          DEPTH_B = 16;
    localparam logic [31:0] BASE_B  = 32'h0000_0100;

    logic        clk   = 1'b0;
    logic        arst  = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  be    = '0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;

    logic        rvalid_a, err_a, rvalid_b, err_b;
    logic [31:0] rdata_a, err_addr_a, rdata_b, err_addr_b;

    always #5 clk = ~clk;

    miriscv_dmem_responder #(
        .XLEN(32), .DEPTH(DEPTH_A), .BASE_ADDR(BASE_A), .LATENCY(LAT_A), .INIT_FILE("")
    ) u_dut_a (
        .clk_i(clk), .arst_i(arst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid_a),
        .data_rdata_o(rdata_a), .err_o(err_a), .err_addr_o(err_addr_a)
    );

    miriscv_dmem_responder #(
        .XLEN(32), .DEPTH(DEPTH_B), .BASE_ADDR(BASE_B), .LATENCY(LAT_B), .INIT_FILE("")
    ) u_dut_b (
        .clk_i(clk), .arst_i(arst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid_b),
        .data_rdata_o(rdata_b), .err_o(err_b), .err_addr_o(err_addr_b)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];
    logic        m_err      [2] = '{1'b0, 1'b0};
    logic [31:0] m_err_addr [2] = '{32'h0, 32'h0};
    logic [31:0] m_last     [2] = '{32'h0, 32'h0};
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    bit          done     = 1'b0;

    // A legal store mask is a contiguous, naturally aligned run of 1, 2 or 4
    // lanes; wider accesses must also start at the lane the address names.
    function automatic bit be_legal(input logic [3:0] b, input logic [1:0] off);
        int size;
        int lane;
        size = $countones(b);
        lane = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) lane = i;
        if (!(size == 1 || size == 2 || size == 4)) return 1'b0;
        if (b != 4'(((1 << size) - 1) << lane)) return 1'b0;
        if (lane % size != 0) return 1'b0;
        return (size == 1) || (int'(off) == lane);
    endfunction

    task automatic model_dut(input int d, input int lat, input int depth, input logic [31:0] base);
        logic [31:0] off;
        logic [31:0] word;
        int          idx;
        bit          in_rng;
        bit          legal;
        off    = addr - base;
        in_rng = (addr >= base) && (off < 32'(depth * 4));
        idx    = int'(off >> 2);
        legal  = 1'b1;
`ifdef MIRISCV_DMEM_BE_CHECK_EN
        legal  = be_legal(be, addr[1:0]);
`endif
        if (!req) return;
        if ((!in_rng || (we && !legal)) && !m_err[d]) begin
            m_err[d]      = 1'b1;
            m_err_addr[d] = addr;
        end
        if (we) begin
            if (in_rng && legal) begin
                word = (d == 0) ? mem_a[idx] : mem_b[idx];
                for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
                if (d == 0) mem_a[idx] = word;
                else        mem_b[idx] = word;
            end
        end else begin
            if (in_rng) word = (d == 0) ? mem_a[idx] : mem_b[idx];
            else        word = 32'hDEAD_BEEF;
            if (d == 0) q_a.push_back('{word, cyc + lat - 1});
            else        q_b.push_back('{word, cyc + lat - 1});
        end
    endtask

    task automatic check_dut(input int d, input logic rv, input logic [31:0] rd,
                             input logic er, input logic [31:0] ea);
        exp_t e;
        bit   have;
        bit   exp_v;
        have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        e    = '{32'h0, -1};
        if (have) e = (d == 0) ? q_a[0] : q_b[0];
        exp_v = have && (e.due == cyc);
        checks++;
        if (rv !== exp_v) begin
            failures++;
            $display("FAIL rvalid dut%0d cyc=%0d actual=%b required=%b", d, cyc, rv, exp_v);
        end
        if (exp_v) begin
            m_last[d] = e.data;
            if (d == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
        end
        checks++;
        if (rd !== m_last[d]) begin
            failures++;
            $display("FAIL rdata dut%0d cyc=%0d actual=%h required=%h", d, cyc, rd, m_last[d]);
        end
        checks++;
        if (er !== m_err[d]) begin
            failures++;
            $display("FAIL err dut%0d cyc=%0d actual=%b required=%b", d, cyc, er, m_err[d]);
        end
        checks++;
        if (ea !== m_err_addr[d]) begin
            failures++;
            $display("FAIL err_addr dut%0d cyc=%0d actual=%h required=%h", d, cyc, ea, m_err_addr[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check_dut(0, rvalid_a, rdata_a, err_a, err_addr_a);
            check_dut(1, rvalid_b, rdata_b, err_b, err_addr_b);
        end
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!arst) begin
            model_dut(0, LAT_A, DEPTH_A, BASE_A);
            model_dut(1, LAT_B, DEPTH_B, BASE_B);
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        req  = 1'b0;
        arst = 1'b1;
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            m_err[d]      = 1'b0;
            m_err_addr[d] = 32'h0;
            m_last[d]     = 32'h0;
        end
        repeat (n) step();
        arst = 1'b0;
    endtask

    initial begin
        do_reset(3);
        // Fill every word of both RAMs so later loads never see unknowns.
        for (int a = 0; a < 32'h140; a += 4) drive(1'b1, 1'b1, 4'hF, 32'(a), 32'(a / 4 + 1));
        do_reset(1);
        idle(2);

        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(4);

        drive(1'b1, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
        drive(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_EE00);
        drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        idle(4);

        for (int a = 0; a < 16; a += 4) drive(1'b1, 1'b0, 4'hF, 32'(a), 32'h0);
        idle(5);

        drive(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFE_0030);
        drive(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        drive(1'b1, 1'b0, 4'hF, 32'h34, 32'h0);
        drive(1'b1, 1'b1, 4'hF, 32'h34, 32'hCAFE_0034);
        drive(1'b1, 1'b0, 4'hF, 32'h34, 32'h0);
        idle(5);

        drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        drive(1'b1, 1'b0, 4'hF, 32'h140, 32'h0);
        drive(1'b1, 1'b1, 4'hF, 32'h80, 32'h5555_AAAA);
        drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        idle(5);

        drive(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drive(1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        do_reset(1);
        idle(6);

        drive(1'b1, 1'b1, 4'b0110, 32'h8, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        drive(1'b1, 1'b1, 4'b0011, 32'h102, 32'h1111_2222);
        drive(1'b1, 1'b1, 4'b1100, 32'h10A, 32'h3333_4444);
        drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        drive(1'b1, 1'b0, 4'hF, 32'h108, 32'h0);
        idle(5);
        do_reset(1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), 32'($urandom_range(0, 32'h17F)), $urandom);
            end
        end
        idle(8);

        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0", q_a.size(), q_b.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
